i2c_slave_passcode_ctrl: RTL and testbench

- Write-only I2C slave that consumes the passcode/OTP-command traffic issued by the bench I2C master.
- Oversamples SCL/SDA and decodes device address, register address and data bytes. Drives ACK as an open-drain pull-down.
- Checks the 6-byte passcode written to REG_PASSCODE. Forwards OTP command bytes written to REG_OTP only while unlocked.

---
 rtl/i2c_passcode_pkg.sv | 34 +++
 rtl/i2c_slave_line_sync.sv | 76 +++++++
 rtl/i2c_slave_passcode_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave_passcode_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_passcode_pkg.sv
// Shared types and constants for the passcode-gated I2C OTP command slave.
package i2c_passcode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEV, ST_ACK_DEV, ST_REG, ST_ACK_REG, ST_DATA, ST_ACK_DATA, ST_IGNORE
  } i2c_state_e;

  localparam logic [6:0] DEV_ADDR_DEF     = 7'h0A;
  localparam logic [7:0] REG_PASSCODE_DEF = 8'h05;
  localparam logic [7:0] REG_OTP_DEF      = 8'h04;
  localparam int         PASSCODE_LEN_DEF = 6;

  localparam logic [0:5][7:0] PASSCODE = {8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};

  localparam logic [7:0] OTP_CMD_RD  = 8'h00;
  localparam logic [7:0] OTP_CMD_WR  = 8'h11;
  localparam logic [7:0] OTP_CMD_NOP = 8'h01;

  // Out-of-range indices map to a value that is never a valid continuation.
  function automatic logic [7:0] passcode_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = PASSCODE[0];
      3'd1:    b = PASSCODE[1];
      3'd2:    b = PASSCODE[2];
      3'd3:    b = PASSCODE[3];
      3'd4:    b = PASSCODE[4];
      3'd5:    b = PASSCODE[5];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_slave_line_sync.sv
// SCL/SDA synchronizers with START/STOP and SCL edge strobes.
// Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample stability filter per line.
module i2c_slave_line_sync (
  input  logic clk_sda,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff_r, sda_ff_r;
  logic       scl_line_s, sda_line_s;
  logic       scl_prev_r, sda_prev_r;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff_r <= 2'b11;
      sda_ff_r <= 2'b11;
    end else begin
      scl_ff_r <= {scl_ff_r[0], scl_in};
      sda_ff_r <= {sda_ff_r[0], sda_in};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r, sda_hist_r;
  logic       scl_filt_r, sda_filt_r;

  // A line only moves once three consecutive samples agree
  assign scl_line_s = (scl_ff_r[1] == scl_hist_r[0] && scl_hist_r[0] == scl_hist_r[1])
                      ? scl_ff_r[1] : scl_filt_r;
  assign sda_line_s = (sda_ff_r[1] == sda_hist_r[0] && sda_hist_r[0] == sda_hist_r[1])
                      ? sda_ff_r[1] : sda_filt_r;

  // Sample history and held filter outputs
  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_ff_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_ff_r[1]};
      scl_filt_r <= scl_line_s;
      sda_filt_r <= sda_line_s;
    end
  end
`else
  assign scl_line_s = scl_ff_r[1];
  assign sda_line_s = sda_ff_r[1];
`endif

  // Previous conditioned levels for edge detection
  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_line_s;
      sda_prev_r <= sda_line_s;
    end
  end

  assign sda      = sda_line_s;
  assign scl_rise = scl_line_s & ~scl_prev_r;
  assign scl_fall = ~scl_line_s & scl_prev_r;
  assign start    = scl_line_s & scl_prev_r & sda_prev_r & ~sda_line_s;
  assign stop     = scl_line_s & scl_prev_r & ~sda_prev_r & sda_line_s;

endmodule

// File: rtl/i2c_slave_passcode_ctrl.sv
// Write-only I2C slave: 6-byte passcode unlock gating OTP command forwarding.
module i2c_slave_passcode_ctrl
  import i2c_passcode_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = DEV_ADDR_DEF,
  parameter logic [7:0] REG_PASSCODE = REG_PASSCODE_DEF,
  parameter logic [7:0] REG_OTP      = REG_OTP_DEF,
  parameter int         PASSCODE_LEN = PASSCODE_LEN_DEF
) (
  input  logic       clk_sda,
  input  logic       rst_n,
  input  logic       i2c_scl,
  input  logic       i2c_sda,
  output logic       sda_oe,
  output logic       unlocked,
  output logic       pass_fail,
  output logic [7:0] otp_cmd,
  output logic       otp_cmd_vld,
  output logic       otp_rd_req,
  output logic       otp_wr_req
);

  localparam logic [2:0] LAST_IDX = 3'(PASSCODE_LEN - 1);

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_slave_line_sync u_line_sync (
    .clk_sda  (clk_sda),
    .rst_n    (rst_n),
    .scl_in   (i2c_scl),
    .sda_in   (i2c_sda),
    .sda      (sda_s),
    .scl_rise (scl_rise_s),
    .scl_fall (scl_fall_s),
    .start    (start_s),
    .stop     (stop_s)
  );

  i2c_state_e state_r, state_nx;
  logic [2:0] bit_cnt_r, bit_cnt_nx, idx_r, idx_nx, eff_idx_s;
  logic [6:0] shift_r, shift_nx;
  logic [7:0] reg_r, reg_nx, otp_cmd_r, otp_cmd_nx, byte_s;
  logic       ack_phase_r, ack_phase_nx, unlocked_r, unlocked_nx, sda_oe_r, sda_oe_nx;
  logic       pass_fail_r, pass_fail_nx, vld_r, vld_nx, rd_r, rd_nx, wr_r, wr_nx;
  logic       in_byte_s, last_bit_s;

  assign byte_s     = {shift_r, sda_s};
  assign in_byte_s  = (state_r == ST_DEV) || (state_r == ST_REG) || (state_r == ST_DATA);
  assign last_bit_s = scl_rise_s && (bit_cnt_r == 3'd7);
  // A passcode write while unlocked restarts the sequence from the first byte
  assign eff_idx_s  = unlocked_r ? 3'd0 : idx_r;

  // State and datapath registers
  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 7'd0;
      reg_r       <= 8'd0;
      idx_r       <= 3'd0;
      ack_phase_r <= 1'b0;
      unlocked_r  <= 1'b0;
      sda_oe_r    <= 1'b0;
      pass_fail_r <= 1'b0;
      otp_cmd_r   <= 8'd0;
      vld_r       <= 1'b0;
      rd_r        <= 1'b0;
      wr_r        <= 1'b0;
    end else begin
      state_r     <= state_nx;
      bit_cnt_r   <= bit_cnt_nx;
      shift_r     <= shift_nx;
      reg_r       <= reg_nx;
      idx_r       <= idx_nx;
      ack_phase_r <= ack_phase_nx;
      unlocked_r  <= unlocked_nx;
      sda_oe_r    <= sda_oe_nx;
      pass_fail_r <= pass_fail_nx;
      otp_cmd_r   <= otp_cmd_nx;
      vld_r       <= vld_nx;
      rd_r        <= rd_nx;
      wr_r        <= wr_nx;
    end
  end

  // Next-state, byte decode, ACK drive and commit
  always_comb begin
    state_nx     = state_r;
    bit_cnt_nx   = bit_cnt_r;
    shift_nx     = shift_r;
    reg_nx       = reg_r;
    idx_nx       = idx_r;
    ack_phase_nx = ack_phase_r;
    unlocked_nx  = unlocked_r;
    sda_oe_nx    = sda_oe_r;
    otp_cmd_nx   = otp_cmd_r;
    pass_fail_nx = 1'b0;
    vld_nx       = 1'b0;
    rd_nx        = 1'b0;
    wr_nx        = 1'b0;
    if (stop_s) begin
      state_nx     = ST_IDLE;
      sda_oe_nx    = 1'b0;
      ack_phase_nx = 1'b0;
    end else if (start_s) begin
      state_nx     = ST_DEV;
      bit_cnt_nx   = 3'd0;
      sda_oe_nx    = 1'b0;
      ack_phase_nx = 1'b0;
    end else begin
      if (in_byte_s && scl_rise_s) begin
        shift_nx   = byte_s[6:0];
        bit_cnt_nx = bit_cnt_r + 3'd1;
      end else begin
        shift_nx   = shift_r;
        bit_cnt_nx = bit_cnt_r;
      end
      case (state_r)
        ST_DEV: begin
          if (last_bit_s) begin
            state_nx = (byte_s[7:1] == DEV_ADDR && !byte_s[0]) ? ST_ACK_DEV : ST_IGNORE;
          end else begin
            state_nx = ST_DEV;
          end
        end
        ST_REG: begin
          if (last_bit_s) begin
            reg_nx   = byte_s;
            state_nx = (byte_s == REG_PASSCODE || byte_s == REG_OTP) ? ST_ACK_REG : ST_IGNORE;
          end else begin
            state_nx = ST_REG;
          end
        end
        ST_DATA: begin
          if (!last_bit_s) begin
            state_nx = ST_DATA;
          end else if (reg_r == REG_PASSCODE) begin
            state_nx = ST_ACK_DATA;
            if (byte_s != passcode_byte(eff_idx_s)) begin
              idx_nx       = 3'd0;
              unlocked_nx  = 1'b0;
              pass_fail_nx = 1'b1;
            end else if (eff_idx_s == LAST_IDX) begin
              idx_nx      = 3'd0;
              unlocked_nx = 1'b1;
            end else begin
              idx_nx      = eff_idx_s + 3'd1;
              unlocked_nx = 1'b0;
            end
          end else if (unlocked_r) begin
            state_nx   = ST_ACK_DATA;
            otp_cmd_nx = byte_s;
            vld_nx     = 1'b1;
            rd_nx      = (byte_s == OTP_CMD_RD);
            wr_nx      = (byte_s == OTP_CMD_WR);
          end else begin
            state_nx = ST_IGNORE;
          end
        end
        ST_ACK_DEV, ST_ACK_REG, ST_ACK_DATA: begin
          if (scl_fall_s && !ack_phase_r) begin
            sda_oe_nx    = 1'b1;
            ack_phase_nx = 1'b1;
          end else if (scl_fall_s) begin
            sda_oe_nx    = 1'b0;
            ack_phase_nx = 1'b0;
            state_nx     = (state_r == ST_ACK_DEV) ? ST_REG : ST_DATA;
          end else begin
            sda_oe_nx = sda_oe_r;
          end
        end
        default: state_nx = state_r;
      endcase
    end
  end

  assign sda_oe      = sda_oe_r;
  assign unlocked    = unlocked_r;
  assign pass_fail   = pass_fail_r;
  assign otp_cmd     = otp_cmd_r;
  assign otp_cmd_vld = vld_r;
  assign otp_rd_req  = rd_r;
  assign otp_wr_req  = wr_r;

endmodule

// File: tb/tb_i2c_slave_passcode_ctrl.sv
// Directed bench: bit-banged I2C master with open-drain bus and pulse counters.
module tb_i2c_slave_passcode_ctrl;
  import i2c_passcode_pkg::*;

  logic       clk_sda = 1'b0;
  logic       rst_n, scl_m, sda_m, i2c_sda;
  logic       sda_oe, unlocked, pass_fail, otp_cmd_vld, otp_rd_req, otp_wr_req;
  logic [7:0] otp_cmd;

  int checks = 0, errors = 0;
  int pf_cnt = 0, vld_cnt = 0, rd_cnt = 0, wr_cnt = 0, oe_cnt = 0;

  assign i2c_sda = sda_m & ~sda_oe;
  always #5 clk_sda = ~clk_sda;

  i2c_slave_passcode_ctrl dut (
    .clk_sda     (clk_sda),
    .rst_n       (rst_n),
    .i2c_scl     (scl_m),
    .i2c_sda     (i2c_sda),
    .sda_oe      (sda_oe),
    .unlocked    (unlocked),
    .pass_fail   (pass_fail),
    .otp_cmd     (otp_cmd),
    .otp_cmd_vld (otp_cmd_vld),
    .otp_rd_req  (otp_rd_req),
    .otp_wr_req  (otp_wr_req)
  );

  // Count high cycles so a stretched pulse shows up as an extra count
  always @(negedge clk_sda) begin
    if (pass_fail)   pf_cnt  <= pf_cnt + 1;
    if (otp_cmd_vld) vld_cnt <= vld_cnt + 1;
    if (otp_rd_req)  rd_cnt  <= rd_cnt + 1;
    if (otp_wr_req)  wr_cnt  <= wr_cnt + 1;
    if (sda_oe)      oe_cnt  <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(negedge clk_sda);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    sda_m = 1'b1; q(); scl_m = 1'b1; q();
    ack = ~i2c_sda;
    q(); scl_m = 1'b0; q();
  endtask

  task automatic txn(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                     output logic [2:0] acks);
    i2c_start();
    wbyte(d0, acks[2]);
    wbyte(d1, acks[1]);
    wbyte(d2, acks[0]);
    i2c_stop();
  endtask

  initial begin
    logic [7:0] pc [6];
    logic [7:0] part;
    logic [2:0] acks;
    logic       a;
    int pf0, vld0, rd0, wr0, oe0;
    pc = '{8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk_sda);
    check("reset_outputs", 32'({sda_oe, unlocked, pass_fail, otp_cmd_vld, otp_rd_req,
                                otp_wr_req, otp_cmd}), 32'd0);
    rst_n = 1'b1; q();

    // Full passcode then OTP read command
    pf0 = pf_cnt; vld0 = vld_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      txn(8'h14, 8'h05, pc[i], acks);
      check("t1_pass_acks", 32'(acks), 32'd7);
      if (i == 4) check("t1_locked_before_last", 32'(unlocked), 32'd0);
    end
    check("t1_unlocked", 32'(unlocked), 32'd1);
    txn(8'h14, 8'h04, 8'h00, acks);
    check("t1_otp_acks", 32'(acks), 32'd7);
    check("t1_otp_cmd", 32'(otp_cmd), 32'h00);
    check("t1_vld_cnt", 32'(vld_cnt - vld0), 32'd1);
    check("t1_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    check("t1_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
    check("t1_pf_cnt", 32'(pf_cnt - pf0), 32'd0);

    // Wrong 4th byte; writing while unlocked relocks
    pf0 = pf_cnt; vld0 = vld_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    txn(8'h14, 8'h05, 8'h50, acks);
    check("t2_relock", 32'(unlocked), 32'd0);
    txn(8'h14, 8'h05, 8'h48, acks);
    txn(8'h14, 8'h05, 8'h53, acks);
    check("t2_pf_before_bad", 32'(pf_cnt - pf0), 32'd0);
    txn(8'h14, 8'h05, 8'h00, acks);
    check("t2_bad_byte_acked", 32'(acks), 32'd7);
    check("t2_pf_cnt", 32'(pf_cnt - pf0), 32'd1);
    txn(8'h14, 8'h04, 8'h11, acks);
    check("t2_locked_otp_nack", 32'(acks), 32'd6);
    check("t2_unlocked", 32'(unlocked), 32'd0);
    check("t2_no_otp_pulses", 32'((vld_cnt - vld0) + (rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    check("t2_otp_cmd_kept", 32'(otp_cmd), 32'h00);

    // Foreign address and read frames are ignored mid-sequence
    txn(8'h14, 8'h05, 8'h50, acks);
    txn(8'h14, 8'h05, 8'h48, acks);
    oe0 = oe_cnt; pf0 = pf_cnt;
    txn(8'h16, 8'h05, 8'h53, acks);
    check("t3_wrong_dev_acks", 32'(acks), 32'd0);
    txn(8'h15, 8'h05, 8'h53, acks);
    check("t3_read_acks", 32'(acks), 32'd0);
    check("t3_no_oe", 32'(oe_cnt - oe0), 32'd0);
    for (int i = 2; i < 6; i++) txn(8'h14, 8'h05, pc[i], acks);
    check("t3_idx_kept_unlock", 32'(unlocked), 32'd1);
    check("t3_no_pf", 32'(pf_cnt - pf0), 32'd0);

    // STOP after 4 data bits discards the partial OTP byte
    vld0 = vld_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    i2c_start(); wbyte(8'h14, a); wbyte(8'h04, a);
    wbit(1'b0); wbit(1'b0); wbit(1'b0); wbit(1'b1);
    i2c_stop();
    check("t4_partial_no_vld", 32'(vld_cnt - vld0), 32'd0);
    check("t4_partial_cmd_kept", 32'(otp_cmd), 32'h00);
    txn(8'h14, 8'h04, 8'h11, acks);
    check("t4_wr_acks", 32'(acks), 32'd7);
    check("t4_otp_cmd", 32'(otp_cmd), 32'h11);
    check("t4_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    check("t4_vld_cnt", 32'(vld_cnt - vld0), 32'd1);
    check("t4_rd_cnt", 32'(rd_cnt - rd0), 32'd0);

    // Repeated START mid-byte after 3 good bytes keeps the index
    for (int i = 0; i < 3; i++) txn(8'h14, 8'h05, pc[i], acks);
    check("t5_locked_mid", 32'(unlocked), 32'd0);
    i2c_start(); wbyte(8'h14, a); wbyte(8'h05, a);
    wbit(1'b1); wbit(1'b1); wbit(1'b1);
    i2c_start(); wbyte(8'h14, a); wbyte(8'h05, a); wbyte(pc[3], a); i2c_stop();
    check("t5_rs_byte_ack", 32'(a), 32'd1);
    for (int i = 4; i < 6; i++) txn(8'h14, 8'h05, pc[i], acks);
    check("t5_unlocked", 32'(unlocked), 32'd1);

    // Reset asserted while the slave drives a data ACK
    vld0 = vld_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    part = OTP_CMD_NOP;
    i2c_start(); wbyte(8'h14, a); wbyte(8'h04, a);
    for (int i = 7; i >= 0; i--) wbit(part[i]);
    sda_m = 1'b1; q();
    check("t6_ack_driven", 32'(sda_oe), 32'd1);
    check("t6_unlocked_pre", 32'(unlocked), 32'd1);
    check("t6_nop_vld_only", 32'({vld_cnt - vld0, rd_cnt - rd0, wr_cnt - wr0}), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", 32'(sda_oe), 32'd0);
    check("t6_rst_unlocked", 32'(unlocked), 32'd0);
    @(negedge clk_sda);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk_sda);
    check("t6_vld_cnt", 32'(vld_cnt - vld0), 32'd1);
    rst_n = 1'b1; q();
    txn(8'h14, 8'h05, 8'h50, acks);
    check("t6_post_rst_acks", 32'(acks), 32'd7);
    check("t6_post_rst_cmd", 32'(otp_cmd), 32'h00);
    check("t6_post_rst_locked", 32'(unlocked), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
